// File: rtl/inst_loader_pkg.sv
// Shared types for the instruction-memory loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/inst_loader.sv
// Instruction-memory loader: streams words into consecutive memory addresses,
// verifies a trailing XOR checksum and holds the CPU in reset until it matches.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int A = 16,
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [A-1:0] BaseAddr,
  input  logic [A-1:0] Length,
  input  logic [W-1:0] InData,
  input  logic         InValid,
  output logic         InReady,
  output logic         WrEn,
  output logic [A-1:0] WrAddr,
  output logic [W-1:0] WrData,
  output logic         Busy,
  output logic         Done,
  output logic         Error,
  output logic         CpuHold
);

  loader_state_t state, state_nxt;
  logic [A-1:0]  addr;
  logic [A-1:0]  remaining;
  logic [W-1:0]  csum;
  logic          xfer;
  logic          can_start;

  assign xfer      = InValid && InReady;
  // Start is only honoured outside an active load.
  assign can_start = (state == IDLE) || (state == DONE) || (state == ERR);

  // NOTE: every variable written here gets a default first, so no latches are inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (Start) state_nxt = (Length == '0) ? DONE : LOAD;
      end
      LOAD: begin
        if (xfer && (remaining == A'(1))) state_nxt = CHECK;
      end
      CHECK: begin
        if (xfer) state_nxt = (InData == csum) ? DONE : ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: only loader registers are reset; the instruction memory itself is never cleared.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      csum      <= '0;
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      WrData    <= '0;
    end else begin
      state <= state_nxt;
      WrEn  <= 1'b0;
      if (can_start && Start) begin
        addr      <= BaseAddr;
        remaining <= Length;
        csum      <= '0;
      end else if ((state == LOAD) && xfer) begin
        WrEn      <= 1'b1;
        WrAddr    <= addr;
        WrData    <= InData;
        csum      <= csum ^ InData;
        addr      <= addr + A'(1);
        remaining <= remaining - A'(1);
      end
    end
  end

  // Status outputs decode directly from the registered state.
  assign InReady = (state == LOAD) || (state == CHECK);
  assign Busy    = InReady;
  assign Done    = (state == DONE);
  assign Error   = (state == ERR);
  assign CpuHold = (state != DONE);

endmodule
